// File: rtl/frog_game_pkg.sv
// Shared types and widths for the frog game-state controller.
package frog_game_pkg;
  typedef enum logic [1:0] {
    PLAY  = 2'd0,
    DYING = 2'd1,
    OVER  = 2'd2
  } state_e;

  localparam int LIVES_W = 3;
  localparam int FRAME_W = 8;
endpackage

// File: rtl/frog_game_ctrl_frame_hit_latch.sv
// Sticky per-frame flag: set by a qualified event, cleared at frame end.
// A set arriving in the same cycle as the clear is dropped.
module frame_hit_latch (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_set,
  input  logic i_clr,
  output logic o_flag
);
  logic flag_r;

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      flag_r <= 1'b0;
    end else if (i_clr) begin
      flag_r <= 1'b0;
    end else if (i_set) begin
      flag_r <= 1'b1;
    end else begin
      flag_r <= flag_r;
    end
  end

  assign o_flag = flag_r;
endmodule

// File: rtl/frog_game_ctrl.sv
// Game-state controller: death, respawn, goal scoring, lives and game-over,
// evaluated once per frame on the animate strobe.
module frog_game_ctrl
  import frog_game_pkg::*;
#(
  parameter int LIVES        = 3,
  parameter int DEATH_FRAMES = 60,
  parameter int FLASH_SHIFT  = 3,
  parameter int GOAL_Y       = 24,
  parameter int SCORE_W      = 8
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_pix_stb,
  input  logic               i_animate,
  input  logic               i_hit,
  input  logic [11:0]        i_frog_y1,
  input  logic               i_restart,
  output logic               o_dead,
  output logic               o_respawn,
  output logic               o_flash,
  output logic [LIVES_W-1:0] o_lives,
  output logic [SCORE_W-1:0] o_score,
  output logic               o_game_over
);
  localparam logic [11:0]        GOAL_Y_V  = 12'(GOAL_Y);
  localparam logic [LIVES_W-1:0] LIVES_V   = LIVES_W'(LIVES);
  localparam logic [FRAME_W-1:0] DEATH_TOP = FRAME_W'(DEATH_FRAMES - 1);
  localparam logic [SCORE_W-1:0] SCORE_MAX = {SCORE_W{1'b1}};

  state_e             state_r, state_s;
  logic [FRAME_W-1:0] frame_cnt_r, frame_cnt_s;
  logic [LIVES_W-1:0] lives_r, lives_s;
  logic [SCORE_W-1:0] score_r, score_s;
  logic               respawn_r, respawn_s;
  logic               dead_r, game_over_r;
  logic               hit_set_s, hit_flag_s;

  // Hazard overlap only counts while the frog is alive and a real pixel is shown.
  assign hit_set_s = i_pix_stb & i_hit & (state_r == PLAY);

  frame_hit_latch u_hit_latch (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_set  (hit_set_s),
    .i_clr  (i_animate),
    .o_flag (hit_flag_s)
  );

  always_comb begin
    state_s     = state_r;
    frame_cnt_s = frame_cnt_r;
    lives_s     = lives_r;
    score_s     = score_r;
    respawn_s   = 1'b0;
    case (state_r)
      PLAY: begin
        if (!i_animate) begin
          state_s = PLAY;
        end else if (hit_flag_s) begin
          state_s     = DYING;
          frame_cnt_s = DEATH_TOP;
        end else if (i_frog_y1 <= GOAL_Y_V) begin
          score_s   = (score_r == SCORE_MAX) ? score_r : score_r + SCORE_W'(1'b1);
          respawn_s = 1'b1;
        end else begin
          state_s = PLAY;
        end
      end
      DYING: begin
        if (!i_animate) begin
          state_s = DYING;
        end else if (frame_cnt_r != {FRAME_W{1'b0}}) begin
          frame_cnt_s = frame_cnt_r - FRAME_W'(1'b1);
        end else begin
          lives_s = lives_r - LIVES_W'(1'b1);
          if (lives_r == LIVES_W'(1'b1)) begin
            state_s = OVER;
          end else begin
            state_s   = PLAY;
            respawn_s = 1'b1;
          end
        end
      end
      OVER: begin
        if (i_animate && i_restart) begin
          state_s   = PLAY;
          lives_s   = LIVES_V;
          score_s   = {SCORE_W{1'b0}};
          respawn_s = 1'b1;
        end else begin
          state_s = OVER;
        end
      end
      default: begin
        state_s = PLAY;
      end
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_r     <= PLAY;
      frame_cnt_r <= {FRAME_W{1'b0}};
      lives_r     <= LIVES_V;
      score_r     <= {SCORE_W{1'b0}};
      respawn_r   <= 1'b0;
      dead_r      <= 1'b0;
      game_over_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      frame_cnt_r <= frame_cnt_s;
      lives_r     <= lives_s;
      score_r     <= score_s;
      respawn_r   <= respawn_s;
      dead_r      <= (state_s != PLAY);
      game_over_r <= (state_s == OVER);
    end
  end

  assign o_dead      = dead_r;
  assign o_respawn   = respawn_r;
  assign o_flash     = (state_r == DYING) & frame_cnt_r[FLASH_SHIFT];
  assign o_lives     = lives_r;
  assign o_score     = score_r;
  assign o_game_over = game_over_r;
endmodule

// File: tb/tb_frog_game_ctrl.sv
// Self-checking bench for frog_game_ctrl: directed frame sequences with random
// pixel activity, checked every cycle against a frame-level game model.
module tb_frog_game_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b0;
  logic        i_pix_stb = 1'b0;
  logic        i_animate = 1'b0;
  logic        i_hit = 1'b0;
  logic [11:0] i_frog_y1 = 12'd100;
  logic        i_restart = 1'b0;
  logic        o_dead, o_respawn, o_flash, o_game_over;
  logic [2:0]  o_lives;
  logic [7:0]  o_score;

  int checks = 0;
  int failures = 0;

  // Game model: alive/dying/over flags, death timer, lives, score.
  bit m_dying, m_over, m_hit, m_resp;
  int m_timer, m_lives, m_score;

  frog_game_ctrl dut (
    .i_clk       (i_clk),
    .i_rst       (i_rst),
    .i_pix_stb   (i_pix_stb),
    .i_animate   (i_animate),
    .i_hit       (i_hit),
    .i_frog_y1   (i_frog_y1),
    .i_restart   (i_restart),
    .o_dead      (o_dead),
    .o_respawn   (o_respawn),
    .o_flash     (o_flash),
    .o_lives     (o_lives),
    .o_score     (o_score),
    .o_game_over (o_game_over)
  );

  always #5 i_clk = ~i_clk;

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_step(input bit rst, pix, hit, anim, restart, input int y);
    bit was_hit;
    if (!rst) begin
      m_dying = 0; m_over = 0; m_hit = 0; m_resp = 0;
      m_timer = 0; m_lives = 3; m_score = 0;
    end else begin
      was_hit = m_hit;
      m_resp = 0;
      if (anim) begin
        if (m_over) begin
          if (restart) begin
            m_over = 0; m_lives = 3; m_score = 0; m_resp = 1;
          end
        end else if (m_dying) begin
          if (m_timer == 0) begin
            m_lives = m_lives - 1;
            m_dying = 0;
            if (m_lives == 0) m_over = 1;
            else m_resp = 1;
          end else begin
            m_timer = m_timer - 1;
          end
        end else if (was_hit) begin
          m_dying = 1; m_timer = 59;
        end else if (y <= 24) begin
          m_score = (m_score < 255) ? m_score + 1 : 255;
          m_resp = 1;
        end
        m_hit = 0;
      end else if (pix && hit && !m_dying && !m_over) begin
        m_hit = 1;
      end
    end
  endtask

  task automatic cyc(input bit rst, pix, hit, anim, restart, input logic [11:0] y);
    i_rst = rst; i_pix_stb = pix; i_hit = hit; i_animate = anim;
    i_restart = restart; i_frog_y1 = y;
    model_step(rst, pix, hit, anim, restart, int'(y));
    @(posedge i_clk);
    #1;
    check("dead",      int'(o_dead),      int'(m_dying || m_over));
    check("respawn",   int'(o_respawn),   int'(m_resp));
    check("flash",     int'(o_flash),     (m_dying && ((m_timer >> 3) & 1) == 1) ? 1 : 0);
    check("lives",     int'(o_lives),     m_lives);
    check("score",     int'(o_score),     m_score);
    check("game_over", int'(o_game_over), int'(m_over));
  endtask

  // rmode: 0 no restart, 1 restart only between animates, 2 restart held throughout.
  task automatic frame(input int len, input int hit_pct, input logic [11:0] y,
                       input int rmode, input bit last_hit, input bit anim_hit);
    bit p, h;
    for (int k = 0; k < len - 1; k++) begin
      p = 1'($urandom_range(1));
      h = ($urandom_range(99) < hit_pct);
      if (!h && !p) h = 1'($urandom_range(1));
      if (last_hit && k == len - 2) begin p = 1'b1; h = 1'b1; end
      cyc(1'b1, p, h, 1'b0, rmode != 0, y);
    end
    cyc(1'b1, anim_hit, anim_hit, 1'b1, rmode == 2, y);
  endtask

  task automatic frames(input int n, input int hit_pct, input logic [11:0] y);
    for (int f = 0; f < n; f++) frame(int'($urandom_range(6, 3)), hit_pct, y, 0, 1'b0, 1'b0);
  endtask

  initial begin
    // Reset held three cycles with noisy inputs.
    for (int k = 0; k < 3; k++)
      cyc(1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 1'($urandom_range(1)),
          1'($urandom_range(1)), 12'd10);
    frames(3, 0, 12'd100);

    // Hit coinciding with animate is lost; hit on the last pixel lands.
    frame(5, 0, 12'd100, 0, 1'b0, 1'b1);
    frame(5, 0, 12'd100, 0, 1'b1, 1'b0);
    frames(61, 30, 12'd100);

    // Goal and hit in the same frame: death wins.
    frame(6, 0, 12'd20, 0, 1'b1, 1'b0);
    frames(61, 0, 12'd100);
    frames(1, 0, 12'd24);
    frames(1, 0, 12'd25);

    // Final death, then restart attempts.
    frame(6, 0, 12'd100, 0, 1'b1, 1'b0);
    frames(62, 20, 12'd100);
    frame(6, 0, 12'd100, 1, 1'b0, 1'b0);
    frame(6, 0, 12'd100, 1, 1'b0, 1'b0);
    frame(6, 0, 12'd100, 2, 1'b0, 1'b0);
    frames(2, 0, 12'd100);

    // Reset in the middle of the dying animation.
    frame(6, 0, 12'd100, 0, 1'b1, 1'b0);
    frames(29, 0, 12'd100);
    cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 12'd100);
    frames(2, 0, 12'd100);

    // Score saturation.
    for (int f = 0; f < 260; f++)
      frame(int'($urandom_range(4, 2)), 0, 12'($urandom_range(24)), 0, 1'b0, 1'b0);
    frames(2, 0, 12'd100);

    // Random soak.
    for (int f = 0; f < 500; f++) begin
      if ($urandom_range(99) == 0) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 12'd100);
      frame(int'($urandom_range(8, 2)), 8, 12'($urandom_range(40)),
            int'($urandom_range(2)), 1'b0, 1'($urandom_range(1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/frog_game_ctrl.md
Name: frog_game_ctrl

Overview:
- Game-state controller directly downstream of the VGA top-level compositing and collision logic.
- Consumes the per-pixel frog/hazard overlap, the frame-end animate strobe and the frog's top edge.
- Decides death, respawn, goal scoring, remaining lives and game-over.
- Drives the frog animator's i_dead input and the HUD/colour logic; replaces the ad-hoc registered "dead" flag.

Parameters:
- LIVES, 3, lives at start of game (1..7).
- DEATH_FRAMES, 60, frames spent in the dying animation (1..255).
- FLASH_SHIFT, 3, o_flash toggles every 2^FLASH_SHIFT frames while dying.
- GOAL_Y, 24, frog counts as home when i_frog_y1 <= GOAL_Y.
- SCORE_W, 8, score counter width.

Ports:
- i_clk  in  1  system clock (100 MHz).
- i_rst  in  1  synchronous, active-low reset.
- i_pix_stb  in  1  pixel strobe; overlap sampled only when high.
- i_animate  in  1  one-cycle pulse at end of active frame.
- i_hit  in  1  frog pixel AND any hazard pixel at current x,y.
- i_frog_y1  in  12  frog top edge.
- i_restart  in  1  any button, level; honoured only in OVER.
- o_dead  out  1  high in DYING and OVER; freezes the frog.
- o_respawn  out  1  one-cycle pulse; frog returns to start position.
- o_flash  out  1  frog blink enable during DYING.
- o_lives  out  3  remaining lives.
- o_score  out  SCORE_W  goals reached, saturating.
- o_game_over  out  1  high in OVER.

Behaviour:
- All state changes on posedge i_clk.
- i_rst low → state PLAY, hit_flag=0, frame_cnt=0, o_lives=LIVES, o_score=0, o_dead=0, o_respawn=0, o_flash=0, o_game_over=0.
- Reset overrides every other input in the same cycle, including mid-DYING.
- hit_flag (sticky per frame):
  - Set when i_pix_stb & i_hit & state==PLAY.
  - Cleared on every i_animate cycle, after evaluation.
  - Set and clear in the same cycle → clear wins; the hit is lost.
  - A hit on the frame's last pixel still lands, because i_animate follows active video.
- PLAY, on i_animate:
  - hit_flag=1 → DYING, frame_cnt=DEATH_FRAMES-1, o_dead=1. Takes priority over goal.
  - else i_frog_y1 <= GOAL_Y → o_score+1 (saturate at all-ones), o_respawn pulse next cycle, stay PLAY.
  - else no change.
- DYING:
  - o_dead=1.
  - On each i_animate: if frame_cnt==0, evaluate the exit below; else frame_cnt-1.
  - o_flash = frame_cnt[FLASH_SHIFT] (combinational from the register).
  - Exit: o_lives-1. New value 0 → OVER. Otherwise → PLAY with o_respawn pulse; o_dead and o_flash drop the same cycle.
  - i_hit ignored.
- OVER:
  - o_dead=1, o_game_over=1, o_flash=0, o_lives=0.
  - i_restart high on an i_animate cycle → PLAY, o_lives=LIVES, o_score=0, o_respawn pulse, o_game_over=0.
  - i_restart outside i_animate is ignored, which provides natural debounce.
- o_respawn:
  - Registered; exactly 1 cycle wide.
  - Asserted the cycle after the transition decision.
  - Never asserted twice per frame.
- Latency: from i_animate to state/o_dead change is 1 cycle.
- Widths: i_frog_y1 is compared unsigned against GOAL_Y zero-extended to 12 bits. frame_cnt is 8 bits.
- No outputs are X after reset; no combinational paths from inputs to outputs except o_flash, which comes from registers only.

Decomposition:
- Shared package frog_game_pkg holds:
  - state enum (PLAY=0, DYING=1, OVER=2);
  - LIVES_W=3;
  - frame counter width 8.
- One natural sub-module: frame_hit_latch (sticky per-frame flag with set-qualifier and frame-clear; set/clear priority as above). It is reusable for future goal-slot and log-riding detection.
- The FSM, lives, score and timer stay in frog_game_ctrl.

Test Plan:
- Reset: hold i_rst=0 for 3 cycles, then release → o_lives=3, o_score=0, o_dead=0, o_game_over=0, no o_respawn during or after.
- Single hit: one i_pix_stb&i_hit pulse mid-frame; at next i_animate, o_dead=1 the following cycle. After 60 further animates: o_lives=2, one o_respawn pulse, o_dead=0. o_flash toggles every 8 frames in between.
- Goal vs hit same frame: i_frog_y1=20 plus a hit → DYING, score stays 0. Next, i_frog_y1=24 with no hit → score=1, one o_respawn pulse. i_frog_y1=25 → score unchanged.
- Game over and restart:
  - Three deaths → o_lives=0, o_game_over=1.
  - i_restart pulsed between animates → ignored.
  - i_restart held across an animate → o_lives=3, o_score=0, o_respawn=1 for one cycle.
- Score saturation, SCORE_W=2: five goals → o_score=3, stays 3.
- Reset mid-DYING (frame_cnt=30) → all outputs at reset values the next cycle. A hit pulse without i_pix_stb never sets hit_flag.
